eca_outbuf_streamer: RTL and testbench
======================================

Name: eca_outbuf_streamer

Overview:
- Downstream drain stage of eca_top. Pops wide parity words from the output-buffer SRAM FIFO (sram_fifo read port) and serializes them into narrow valid/ready beats for the host.
- Frames the stream by marking the packet boundary (one of M parity packets) and the stripe boundary (after the M-th packet).
- Replaces the raw outbuf_rd_req / outbuf_rd_data_val / outbuf_rd_data user interface.

Parameters:
- INBUF_DATA_W, 512, FIFO word width; must equal the output-buffer width.
- OUT_W, 64, host beat width; INBUF_DATA_W/OUT_W = R must be a power of 2, R >= 2.
- M_MAX, 4, maximum parity packets per stripe.
- WPP_MAX, 16, maximum FIFO words per packet.
- M_W, $clog2(M_MAX+1), width of m_val.
- WPP_W, $clog2(WPP_MAX+1), width of words_per_pkt.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- eca_en  in  1  enables issuing FIFO reads.
- m_val  in  M_W  parity packets per stripe (1..M_MAX).
- words_per_pkt  in  WPP_W  FIFO words per packet (1..WPP_MAX).
- outbuf_empty  in  1  FIFO empty flag.
- outbuf_rd_req  out  1  FIFO pop request, one word per cycle asserted.
- outbuf_rd_data_val  in  1  read data valid, exactly 1 cycle after rd_req.
- outbuf_rd_data  in  INBUF_DATA_W  read data.
- out_valid  out  1  beat valid.
- out_ready  in  1  host accepts beat.
- out_data  out  OUT_W  beat payload.
- out_last_pkt  out  1  last beat of current packet.
- out_last_stripe  out  1  last beat of stripe (implies out_last_pkt).
- out_pkt_idx  out  M_W  index of current parity packet, 0..m_val-1.
- stripe_done  out  1  1-cycle pulse after the last stripe beat is accepted.
- cfg_err  out  1  level, high while m_val or words_per_pkt is 0 or above its maximum.
- busy  out  1  stripe in progress or data buffered/outstanding.

Behaviour:
- Reset: all outputs 0. Buffers are empty, outstanding count is 0, counters are 0, and the FSM is in IDLE.
- Buffering: 2-entry word buffer (head + prefetch).
  - rd_req = eca_en & ~outbuf_empty & ~cfg_err & (occupied + outstanding < 2).
  - outstanding is 0..1. It increments on rd_req and decrements on rd_data_val.
  - rd_data_val with outstanding == 0 is ignored.
- Latency: first beat out_valid 2 cycles after the first rd_req. Steady state is back-to-back beats with no bubbles between words while the FIFO is non-empty and out_ready is held high.
- Serialization: the head word is emitted LSB first, beat b = word[b*OUT_W +: OUT_W], b = 0..R-1. The head is freed when beat R-1 is accepted, and the prefetch word moves to head the same cycle.
- Handshake: a beat transfers on out_valid & out_ready. While out_valid & ~out_ready, out_data and all flags hold stable. out_valid never drops without a transfer, except on reset.
- FSM:
  - IDLE -> RUN when the first word enters head. m_val and words_per_pkt are latched at this point.
  - RUN -> IDLE on acceptance of the out_last_stripe beat; stripe_done pulses the next cycle.
  - If data is already buffered, the next stripe starts immediately and config is re-latched.
- Counters (latched config): beat_cnt 0..R-1, word_cnt 0..wpp-1, pkt_cnt 0..m-1. All wrap to 0 at their terminal value on acceptance.
  - out_last_pkt = beat_cnt==R-1 & word_cnt==wpp-1.
  - out_last_stripe = out_last_pkt & pkt_cnt==m-1.
  - out_pkt_idx = pkt_cnt.
- Config changes mid-stripe: ignored until the next stripe start.
- cfg_err: blocks new rd_req only. Already-buffered words still drain using the latched config.
- eca_en low mid-stripe: no new reads. The outstanding read is still captured, and buffered beats continue to drain.
- busy = (state==RUN) | occupied!=0 | outstanding!=0.
- rst mid-operation: everything clears immediately. A rd_data_val arriving the cycle after reset release is ignored because outstanding is 0.

Test Plan:
- Single stripe, out_ready=1. INBUF_DATA_W=512, OUT_W=64, m_val=2, wpp=1, FIFO holds words 0xA.., 0xB..
  - Expect 16 contiguous beats, out_pkt_idx 0 for beats 0-7 and 1 for beats 8-15.
  - out_last_pkt on beats 7 and 15; out_last_stripe only on beat 15.
  - stripe_done on the cycle after beat 15.
- Backpressure: toggle out_ready every other cycle, m_val=1, wpp=2.
  - out_data and flags stay stable during stall cycles, all 16 beats arrive in LSB-first order, and outbuf_rd_req is never asserted with 2 words buffered.
- FIFO underrun: assert outbuf_empty after one word, release 10 cycles later.
  - out_valid drops after beat 7, resumes with beat 8 two cycles after the next rd_req, and counters continue (word_cnt=1).
- Config: m_val=0 -> cfg_err=1, no rd_req. Set m_val=3 mid-stripe with latched m_val=1 -> current stripe ends after 1 packet, and the next stripe uses 3.
- Reset mid-stripe after beat 3: all outputs 0 next cycle, busy=0, and a rd_data_val pulse delivered post-release is ignored (out_valid stays 0).
- eca_en drop with 1 outstanding read: the outstanding word is captured and drained (8 beats), and no further rd_req while eca_en=0.

Source files
------------

// File: rtl/eca_outbuf_streamer.sv
// Drains wide parity words from the output-buffer FIFO and serializes them LSB-first into host beats.
// Frames the stream with packet and stripe boundaries. The first beat appears 2 cycles after the first pop.
module eca_outbuf_streamer #(
  parameter int INBUF_DATA_W = 512,
  parameter int OUT_W        = 64,
  parameter int M_MAX        = 4,
  parameter int WPP_MAX      = 16,
  parameter int M_W          = $clog2(M_MAX + 1),
  parameter int WPP_W        = $clog2(WPP_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    eca_en,
  input  logic [M_W-1:0]          m_val,
  input  logic [WPP_W-1:0]        words_per_pkt,
  input  logic                    outbuf_empty,
  output logic                    outbuf_rd_req,
  input  logic                    outbuf_rd_data_val,
  input  logic [INBUF_DATA_W-1:0] outbuf_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_last_pkt,
  output logic                    out_last_stripe,
  output logic [M_W-1:0]          out_pkt_idx,
  output logic                    stripe_done,
  output logic                    cfg_err,
  output logic                    busy
);
  localparam int R  = INBUF_DATA_W / OUT_W;
  localparam int BW = $clog2(R);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [INBUF_DATA_W-1:0] head_q, head_d, pf_q, pf_d;
  logic                    head_vld_q, head_vld_d, pf_vld_q, pf_vld_d;
  logic                    outst_q, outst_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic [WPP_W-1:0]        word_q, word_d, wpp_q, wpp_d;
  logic [M_W-1:0]          pkt_q, pkt_d, m_q, m_d;
  logic                    done_q, done_d;

  logic                    cfg_bad, cap, xfer, pop, latch;
  logic                    last_beat, last_word, last_pkt_int, last_str_int;
  logic [1:0]              fill;
  logic [R-1:0][OUT_W-1:0] head_beats;

  assign cfg_bad = (m_val == '0) || (m_val > M_W'(M_MAX)) ||
                   (words_per_pkt == '0) || (words_per_pkt > WPP_W'(WPP_MAX));
  // Buffered plus in-flight words never exceed the two buffer slots.
  assign fill = {1'b0, head_vld_q} + {1'b0, pf_vld_q} + {1'b0, outst_q};

  assign outbuf_rd_req = ~rst & eca_en & ~outbuf_empty & ~cfg_bad & (fill < 2'd2);
  assign cfg_err       = ~rst & cfg_bad;
  assign cap           = outbuf_rd_data_val & outst_q;

  assign head_beats   = head_q;
  assign last_beat    = (beat_q == BW'(R - 1));
  assign last_word    = (word_q == wpp_q - WPP_W'(1));
  assign last_pkt_int = last_beat & last_word;
  assign last_str_int = last_pkt_int & (pkt_q == m_q - M_W'(1));
  assign xfer         = head_vld_q & out_ready;
  assign pop          = xfer & last_beat;

  assign out_valid       = head_vld_q;
  assign out_data        = head_vld_q ? head_beats[beat_q] : '0;
  assign out_last_pkt    = head_vld_q & last_pkt_int;
  assign out_last_stripe = head_vld_q & last_str_int;
  assign out_pkt_idx     = pkt_q;
  assign stripe_done     = done_q;
  assign busy            = (state_q == RUN) | head_vld_q | pf_vld_q | outst_q;

  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    pf_d       = pf_q;
    pf_vld_d   = pf_vld_q;
    outst_d    = outbuf_rd_req ? 1'b1 : (cap ? 1'b0 : outst_q);
    if (pop) begin
      if (pf_vld_q) begin
        head_d     = pf_q;
        head_vld_d = 1'b1;
        pf_vld_d   = cap;
        if (cap) pf_d = outbuf_rd_data;
      end else begin
        head_vld_d = cap;
        if (cap) head_d = outbuf_rd_data;
      end
    end else if (cap) begin
      if (!head_vld_q) begin
        head_d     = outbuf_rd_data;
        head_vld_d = 1'b1;
      end else begin
        pf_d     = outbuf_rd_data;
        pf_vld_d = 1'b1;
      end
    end
  end

  // Counters reach their terminal values together at stripe end, so they are zero at every stripe start.
  always_comb begin
    beat_d = beat_q;
    word_d = word_q;
    pkt_d  = pkt_q;
    if (xfer) begin
      beat_d = beat_q + BW'(1);
      if (last_beat) begin
        word_d = last_word ? '0 : word_q + WPP_W'(1);
        if (last_word) pkt_d = last_str_int ? '0 : pkt_q + M_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    m_d     = m_q;
    wpp_d   = wpp_q;
    done_d  = xfer & last_str_int;
    case (state_q)
      IDLE: begin
        if (head_vld_d) begin
          state_d = RUN;
          latch   = 1'b1;
        end
      end
      RUN: begin
        if (xfer && last_str_int) begin
          if (head_vld_d) latch = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // An invalid config at stripe start keeps the previous latched values.
    if (latch && !cfg_bad) begin
      m_d   = m_val;
      wpp_d = words_per_pkt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      head_q     <= '0;
      head_vld_q <= 1'b0;
      pf_q       <= '0;
      pf_vld_q   <= 1'b0;
      outst_q    <= 1'b0;
      beat_q     <= '0;
      word_q     <= '0;
      pkt_q      <= '0;
      m_q        <= M_W'(1);
      wpp_q      <= WPP_W'(1);
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      pf_q       <= pf_d;
      pf_vld_q   <= pf_vld_d;
      outst_q    <= outst_d;
      beat_q     <= beat_d;
      word_q     <= word_d;
      pkt_q      <= pkt_d;
      m_q        <= m_d;
      wpp_q      <= wpp_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_eca_outbuf_streamer.sv
// Bench for eca_outbuf_streamer: directed scenarios plus randomized traffic,
// scored against a beat-stream model built from FIFO pops and stripe framing arithmetic.
module tb_eca_outbuf_streamer;
  localparam int DW = 512;
  localparam int OW = 64;
  localparam int R  = DW / OW;
  localparam int MW = 3;
  localparam int WW = 5;

  logic          clk = 1'b0;
  logic          rst, eca_en, outbuf_empty, outbuf_rd_req, rd_val;
  logic [MW-1:0] m_val, out_pkt_idx;
  logic [WW-1:0] wpp;
  logic [DW-1:0] rd_data;
  logic          out_valid, out_ready, out_last_pkt, out_last_stripe;
  logic [OW-1:0] out_data;
  logic          stripe_done, cfg_err, busy;

  always #5 clk = ~clk;

  eca_outbuf_streamer dut (
    .clk(clk), .rst(rst), .eca_en(eca_en), .m_val(m_val), .words_per_pkt(wpp),
    .outbuf_empty(outbuf_empty), .outbuf_rd_req(outbuf_rd_req),
    .outbuf_rd_data_val(rd_val), .outbuf_rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last_pkt(out_last_pkt), .out_last_stripe(out_last_stripe),
    .out_pkt_idx(out_pkt_idx), .stripe_done(stripe_done), .cfg_err(cfg_err), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] fifo_q[$];
  logic [OW-1:0] beats_q[$];
  logic [DW-1:0] pend_word;
  bit  pend, lat_v, done_exp, force_empty, prev_v, prev_r;
  int  n, lat_m, lat_w, ready_mode, cyc;
  int  acc_cnt, req_cnt, done_cnt, first_req, first_vld, first_acc, last_acc;

  function automatic logic [DW-1:0] mkword(input logic [31:0] tag);
    logic [DW-1:0] w;
    for (int b = 0; b < R; b++) w[b*OW +: OW] = {tag, 32'(b)};
    return w;
  endfunction

  function automatic logic [DW-1:0] rndword();
    logic [DW-1:0] w;
    for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic clr();
    acc_cnt = 0; req_cnt = 0; done_cnt = 0;
    first_req = -1; first_vld = -1; first_acc = -1; last_acc = -1;
  endtask

  task automatic monitor();
    bit exp_err, exp_req;
    int words_in, bpp;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      exp_err  = (m_val == 0) || (m_val > 4) || (wpp == 0) || (wpp > 16);
      words_in = (beats_q.size() + R - 1) / R;
      exp_req  = eca_en && !outbuf_empty && !exp_err && (words_in < 2);
      chk("cfg_err", 64'(cfg_err), 64'(exp_err));
      chk("rd_req", 64'(outbuf_rd_req), 64'(exp_req));
      chk("stripe_done", 64'(stripe_done), 64'(done_exp));
      if (stripe_done) done_cnt++;
      done_exp = 0;
      if (prev_v && !prev_r) chk("valid_hold", 64'(out_valid), 64'd1);
      if (out_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (beats_q.size() == 0) begin
          chk("valid_without_data", 64'(out_valid), 64'd0);
        end else begin
          if (!lat_v) begin lat_v = 1; lat_m = int'(m_val); lat_w = int'(wpp); end
          bpp = R * lat_w;
          chk("out_data", 64'(out_data), 64'(beats_q[0]));
          chk("out_pkt_idx", 64'(out_pkt_idx), 64'(n / bpp));
          chk("out_last_pkt", 64'(out_last_pkt), 64'((n % bpp) == bpp - 1));
          chk("out_last_stripe", 64'(out_last_stripe), 64'(n == bpp * lat_m - 1));
          if (out_ready) begin
            void'(beats_q.pop_front());
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            n++;
            if (n == bpp * lat_m) begin n = 0; lat_v = 0; done_exp = 1; end
          end
        end
      end
      prev_v = out_valid; prev_r = out_ready;
      if (outbuf_rd_req) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
        if (fifo_q.size() == 0) begin
          chk("req_on_empty", 64'(outbuf_rd_req), 64'd0);
        end else begin
          pend = 1;
          pend_word = fifo_q.pop_front();
          for (int b = 0; b < R; b++) beats_q.push_back(pend_word[b*OW +: OW]);
        end
      end
    end
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
    rd_val = pend;
    if (pend) rd_data = pend_word;
    pend = 0;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    outbuf_empty = (fifo_q.size() == 0) || force_empty;
  endtask

  task automatic cycle();
    monitor();
    drive();
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k = 0;
    while (acc_cnt < target && k < budget) begin cycle(); k++; end
    chk("wait_timeout", 64'(acc_cnt >= target), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rd_req"}, 64'(outbuf_rd_req), 64'd0);
    chk({tag, "_data"}, 64'(out_data), 64'd0);
    chk({tag, "_flags"}, 64'({out_last_pkt, out_last_stripe, stripe_done, cfg_err}), 64'd0);
    chk({tag, "_idx"}, 64'(out_pkt_idx), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic model_reset();
    beats_q.delete(); fifo_q.delete();
    pend = 0; n = 0; lat_v = 0; done_exp = 0; prev_v = 0; prev_r = 0;
  endtask

  initial begin
    rst = 1'b1; eca_en = 1'b0; m_val = 3'd1; wpp = 5'd1; outbuf_empty = 1'b1;
    rd_val = 1'b0; rd_data = '0; out_ready = 1'b0; ready_mode = 3; force_empty = 0;
    cyc = 0;
    model_reset();
    clr();
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single stripe, two packets of one word each
    m_val = 3'd2; wpp = 5'd1; ready_mode = 0; eca_en = 1'b1;
    fifo_q.push_back(mkword(32'hAAAA_0000)); fifo_q.push_back(mkword(32'hBBBB_0000));
    clr();
    wait_acc(16, 60);
    repeat (4) cycle();
    chk("t1_latency", 64'(first_vld - first_req), 64'd2);
    chk("t1_contiguous", 64'(last_acc - first_acc), 64'd15);
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Backpressure with ready toggling
    m_val = 3'd1; wpp = 5'd2; ready_mode = 1;
    fifo_q.push_back(mkword(32'hCCCC_0000)); fifo_q.push_back(mkword(32'hDDDD_0000));
    clr();
    wait_acc(16, 100);
    repeat (4) cycle();
    chk("t2_reqs", 64'(req_cnt), 64'd2);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);

    // Underrun between the two words of a packet
    ready_mode = 0;
    fifo_q.push_back(mkword(32'hEEEE_0000));
    clr();
    wait_acc(8, 40);
    repeat (10) cycle();
    chk("t3_gap_valid", 64'(out_valid), 64'd0);
    chk("t3_gap_busy", 64'(busy), 64'd1);
    chk("t3_gap_done", 64'(done_cnt), 64'd0);
    first_req = -1; first_vld = -1;
    fifo_q.push_back(mkword(32'hFFFF_0000));
    wait_acc(16, 40);
    repeat (4) cycle();
    chk("t3_resume_latency", 64'(first_vld - first_req), 64'd2);
    chk("t3_done_cnt", 64'(done_cnt), 64'd1);

    // Invalid config blocks reads; mid-stripe m_val change applies to the next stripe
    m_val = 3'd0; wpp = 5'd1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(mkword(32'h1234_0000 + 32'(i)));
    clr();
    repeat (6) cycle();
    chk("t4_cfg_err", 64'(cfg_err), 64'd1);
    chk("t4_no_req", 64'(req_cnt), 64'd0);
    m_val = 3'd1;
    wait_acc(3, 30);
    m_val = 3'd3;
    wait_acc(32, 80);
    repeat (4) cycle();
    chk("t4_done_cnt", 64'(done_cnt), 64'd2);

    // Reset in the middle of a stripe
    m_val = 3'd1; wpp = 5'd1;
    fifo_q.push_back(mkword(32'h5555_0000)); fifo_q.push_back(mkword(32'h6666_0000));
    clr();
    wait_acc(4, 30);
    rst = 1'b1; eca_en = 1'b0; rd_val = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("t5_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    rd_val = 1'b1; rd_data = mkword(32'hDEAD_0000);
    repeat (4) cycle();
    chk("t5_stray_valid", 64'(out_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);

    // eca_en drops while one read is outstanding
    eca_en = 1'b1; ready_mode = 0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(mkword(32'h7777_0000 + 32'(i)));
    clr();
    begin
      int k = 0;
      while (req_cnt == 0 && k < 20) begin cycle(); k++; end
    end
    eca_en = 1'b0;
    repeat (20) cycle();
    chk("t6_drained", 64'(acc_cnt), 64'd8);
    chk("t6_reqs", 64'(req_cnt), 64'd1);
    chk("t6_no_req", 64'(outbuf_rd_req), 64'd0);
    eca_en = 1'b1;
    wait_acc(24, 60);

    // Randomized traffic, one config per phase
    for (int ph = 0; ph < 3; ph++) begin
      m_val = 3'($urandom_range(1, 4)); wpp = 5'($urandom_range(1, 3));
      ready_mode = 2; eca_en = 1'b1;
      clr();
      for (int c = 0; c < 300; c++) begin
        eca_en = ($urandom_range(0, 9) != 0);
        force_empty = ($urandom_range(0, 6) == 0);
        if (fifo_q.size() < 3) fifo_q.push_back(rndword());
        cycle();
      end
      eca_en = 1'b0; force_empty = 0; ready_mode = 0;
      begin
        int k = 0;
        while (beats_q.size() != 0 && k < 200) begin cycle(); k++; end
        chk("rand_drain", 64'(beats_q.size()), 64'd0);
      end
      repeat (3) cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
